// File: rtl/shift_sequencer.sv
// shift_sequencer: splits a 0..15-bit left/right shift request into
// passes of at most STEP_MAX bits on an external single-step shifter.
//
// Ports:
//   Clk, Reset_n      clock, asynchronous active-low reset
//   Start             request strobe, sampled only when idle
//   Data, Dir, Amount operand, direction (0 left, 1 right), distance
//   ShSource/ShEn/ShAmt  drive the shifter's Source/Shift/Shamt
//   ShResult          combinational result returned by the shifter
//   Busy, Done, Out   status, one-cycle completion pulse, result register
module shift_sequencer #(
    parameter int WIDTH    = 8,
    parameter int AMT_W    = 4,
    parameter int STEP_MAX = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    input  logic             Dir,
    input  logic [AMT_W-1:0] Amount,
    output logic [WIDTH-1:0] ShSource,
    output logic             ShEn,
    output logic [2:0]       ShAmt,
    input  logic [WIDTH-1:0] ShResult,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AMT_W:0]   LP_WIDTH = (AMT_W+1)'(WIDTH);
    localparam logic [AMT_W-1:0] LP_STEP  = AMT_W'(STEP_MAX);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [AMT_W-1:0] r_rem;
    logic             r_dir;
    logic [WIDTH-1:0] r_out;

    logic [1:0]       w_step;
    logic             w_last;
    logic             w_ld;
    logic             w_pass;
    logic             w_out_en;
    logic [WIDTH-1:0] w_out_val;

    // Pass size is clamped to the shifter's 2-bit magnitude.
    assign w_step = (r_rem > LP_STEP) ? 2'(STEP_MAX) : r_rem[1:0];
    assign w_last = (r_rem <= LP_STEP);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ld      = 1'b0;
        w_pass    = 1'b0;
        w_out_en  = 1'b0;
        w_out_val = '0;
        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_ld = 1'b1;
                    if (Amount == '0) begin
                        w_next    = S_DONE;
                        w_out_en  = 1'b1;
                        w_out_val = Data;
                    end else if ({1'b0, Amount} >= LP_WIDTH) begin
                        // Everything shifts out; no shifter passes needed.
                        w_next    = S_DONE;
                        w_out_en  = 1'b1;
                        w_out_val = '0;
                    end else begin
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_pass = 1'b1;
                if (w_last) begin
                    w_next    = S_DONE;
                    w_out_en  = 1'b1;
                    w_out_val = ShResult;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_acc <= '0;
            r_rem <= '0;
            r_dir <= 1'b0;
            r_out <= '0;
        end else begin
            if (w_ld) begin
                r_acc <= Data;
                r_rem <= Amount;
                r_dir <= Dir;
            end else if (w_pass) begin
                r_acc <= ShResult;
                r_rem <= r_rem - AMT_W'(w_step);
            end
            if (w_out_en) begin
                r_out <= w_out_val;
            end
        end
    end

    assign ShEn     = (r_state == S_RUN);
    assign ShAmt    = ShEn ? {r_dir, w_step} : 3'b000;
    assign ShSource = r_acc;
    assign Busy     = (r_state != S_IDLE);
    assign Done     = (r_state == S_DONE);
    assign Out      = r_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized self-checking bench for shift_sequencer
// with a behavioural shifter and a whole-request reference model.
module tb_shift_sequencer;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic [7:0] Data;
    logic       Dir;
    logic [3:0] Amount;
    logic [7:0] ShSource;
    logic       ShEn;
    logic [2:0] ShAmt;
    logic [7:0] ShResult;
    logic       Busy;
    logic       Done;
    logic [7:0] Out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] prev_out;

    shift_sequencer dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Data     (Data),
        .Dir      (Dir),
        .Amount   (Amount),
        .ShSource (ShSource),
        .ShEn     (ShEn),
        .ShAmt    (ShAmt),
        .ShResult (ShResult),
        .Busy     (Busy),
        .Done     (Done),
        .Out      (Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single-step shifter: passes Source through when not shifting.
    always_comb begin
        ShResult = ShSource;
        if (ShEn) begin
            if (ShAmt[2]) ShResult = ShSource >> ShAmt[1:0];
            else          ShResult = ShSource << ShAmt[1:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request at the current negedge and follow it to Done.
    task automatic run_op(input logic [7:0] d, input logic dir,
                          input logic [3:0] amt, input bit hold);
        logic [7:0] e_out;
        int         e_lat;
        int         rem;
        int         s;
        int         cyc;
        bit         seen;
        logic [2:0] e_q[$];
        logic [2:0] g_q[$];

        e_out = dir ? (d >> amt) : (d << amt);
        if (amt == 0 || amt >= 8) e_lat = 1;
        else                      e_lat = (int'(amt) + 2) / 3 + 1;
        if (amt >= 1 && amt <= 7) begin
            rem = int'(amt);
            while (rem > 0) begin
                s = (rem < 3) ? rem : 3;
                e_q.push_back({dir, 2'(s)});
                rem -= s;
            end
        end

        Data = d; Dir = dir; Amount = amt; Start = 1'b1;
        cyc  = 0;
        seen = 0;
        while (!seen) begin
            @(negedge Clk);
            cyc++;
            if (!hold) Start = 1'b0;
            Data   = 8'($urandom);
            Dir    = 1'($urandom);
            Amount = 4'($urandom);
            if (ShEn) g_q.push_back(ShAmt);
            if (Done) begin
                seen = 1;
            end else begin
                chk("busy", {31'd0, Busy}, 32'd1);
                chk("out_hold", {24'd0, Out}, {24'd0, prev_out});
                if (cyc > 30) begin
                    chk("timeout", 32'd1, 32'd0);
                    seen = 1;
                end
            end
        end
        chk("latency", cyc, e_lat);
        chk("out", {24'd0, Out}, {24'd0, e_out});
        chk("npass", g_q.size(), e_q.size());
        for (int i = 0; i < e_q.size() && i < g_q.size(); i++)
            chk("shamt", {29'd0, g_q[i]}, {29'd0, e_q[i]});
        prev_out = e_out;
        Start = 1'b0;
        @(negedge Clk);
        chk("idle", {30'd0, Busy, Done}, 32'd0);
        chk("out_keep", {24'd0, Out}, {24'd0, prev_out});
    endtask

    initial begin
        Reset_n  = 1'b0;
        Start    = 1'b0;
        Data     = '0;
        Dir      = 1'b0;
        Amount   = '0;
        prev_out = '0;
        #1;
        chk("reset", {15'd0, ShEn, ShAmt, ShSource, Busy, Done, Out}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_reset", {30'd0, Busy, Done}, 32'd0);

        run_op(8'hB5, 1'b0, 4'd5, 0);
        run_op(8'hB5, 1'b1, 4'd7, 0);
        run_op(8'h3C, 1'b0, 4'd0, 0);
        run_op(8'hFF, 1'b0, 4'd9, 0);
        run_op(8'hC3, 1'b1, 4'd5, 1);

        // Abort an Amount=7 request during its second shifter pass.
        Data = 8'hE7; Dir = 1'b1; Amount = 4'd7; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("abort_run", {31'd0, ShEn}, 32'd1);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("abort_zero",
            {15'd0, ShEn, ShAmt, ShSource, Busy, Done, Out}, 32'd0);
        prev_out = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("no_done", {30'd0, Busy, Done}, 32'd0);
        end
        run_op(8'h81, 1'b0, 4'd1, 0);

        for (int i = 0; i < 40; i++)
            run_op(8'($urandom), 1'($urandom), 4'($urandom),
                   ($urandom_range(0, 3) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
